button_event: RTL
=================

# button_event

Converts the debounced level of a push-button into discrete single-cycle events:

- press
- release
- long-press
- optional auto-repeat

It sits directly downstream of the debouncer and consumes its `clean` output. It feeds control logic (mode selection, threshold stepping) that needs edge events rather than levels. It contains no synchronizer, so its input must already be synchronous to `clk`.

## Interface

Parameters:
- `LONG_CYCLES`, default 50_000_000: cycles from the press event to the long-press event; must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of repeat events while in long-hold; must be ≥ 2.
- `CNT_BITS`, default 26: counter width; must hold max(`LONG_CYCLES`, `REPEAT_CYCLES`) − 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `clean`  in  1  debounced button level (1 = pressed)
- `press`  out  1  one-cycle pulse on rising edge of `clean`
- `release`  out  1  one-cycle pulse on falling edge of `clean`
- `long_press`  out  1  one-cycle pulse after `LONG_CYCLES` of continuous hold
- `repeat`  out  1  one-cycle pulse every `REPEAT_CYCLES` during long-hold
- `held`  out  1  level; high from the `press` cycle through the cycle before `release`

## Operation

- `clean` is registered into `clean_q`. An edge is detected when `clean` differs from `clean_q`.
- FSM states:
  - `IDLE`
  - `SHORT` (held, long threshold not reached)
  - `LONG` (held, long-press already issued)
- Transitions:
  - `IDLE` → `SHORT` on a rising edge: `press` = 1, count ← 0.
  - `SHORT`: while `clean` = 1, count increments each cycle. When count == `LONG_CYCLES` − 1, go to `LONG`: `long_press` = 1, count ← 0.
  - `LONG`: while `clean` = 1, count increments. When count == `REPEAT_CYCLES` − 1: `repeat` = 1, count ← 0 (only when the auto-repeat feature is compiled in).
  - `SHORT` or `LONG` → `IDLE` on a falling edge: `release` = 1, count ← 0.
- Simultaneous events:
  - If the falling edge coincides with counter expiry, release wins: no `long_press` or `repeat` that cycle.
- At most one event output is high in any cycle.
- The counter saturates only by wrap to 0 at expiry and never overflows `CNT_BITS`.

## Timing

- All outputs are registered.
- Reset values: `press`, `release`, `long_press`, `repeat`, `held` = 0. State = `IDLE`, count = 0, `clean_q` = 0.
- `press` is high in the cycle after the first clock edge that samples `clean` = 1. `held` rises in the same cycle.
- `long_press` is high exactly `LONG_CYCLES` cycles after the `press` cycle, if `clean` stayed high throughout.
- First `repeat` comes `REPEAT_CYCLES` cycles after `long_press`, then every `REPEAT_CYCLES` cycles.
- `release` is high in the cycle after the first edge sampling `clean` = 0. `held` falls in the same cycle.
- Reset mid-hold: all outputs clear immediately (asynchronous). If `clean` is still high after reset deasserts, a fresh `press` is generated on the first sampling edge.
- Back-to-back press/release pulses, one cycle apart, are handled without loss.

## Configuration

- `BUTTON_AUTOREPEAT_EN` defined:
  - `repeat` behaves as described above.
- `BUTTON_AUTOREPEAT_EN` undefined:
  - `repeat` is tied to 0.
  - The counter stops and holds at 0 in `LONG`.
  - The `REPEAT_CYCLES` logic is removed.
  - The `repeat` port remains present.

## Structure

- Shared package `button_pkg` holds:
  - the FSM state typedef `btn_state_t` (`IDLE`, `SHORT`, `LONG`)
  - a constant `BTN_CNT_BITS_DEFAULT`
- One sub-module, `event_timer`, is natural:
  - loadable down-free up-counter with clear, enable and terminal-count compare (`limit` input)
  - reused for both the long and repeat thresholds
- The FSM and edge detect live in `button_event`.

## Test plan

All scenarios use bench parameters `LONG_CYCLES` = 8, `REPEAT_CYCLES` = 4, `CNT_BITS` = 4.

1. Short tap: `clean` high for 3 cycles → `press` once, then `release` exactly 3 cycles later; no `long_press`; `held` high for 3 cycles.
2. Long hold (`BUTTON_AUTOREPEAT_EN` defined): `clean` high 20 cycles → `press` at t, `long_press` at t+8, `repeat` at t+12 and t+16, `release` at t+20.
3. Same stimulus as scenario 2 without `BUTTON_AUTOREPEAT_EN` → `long_press` at t+8, `repeat` never asserts, `release` at t+20.
4. Release coincident with expiry: `clean` falls so the edge sampling 0 is the expiry edge (hold of exactly 8 cycles) → `release` only, no `long_press`.
5. Reset mid-hold: assert `reset` at t+5 of a hold, deassert 2 cycles later with `clean` still high → outputs 0 during reset; `press` on the first sampling edge after deassert; `long_press` 8 cycles after that `press`.
6. Rapid toggling: `clean` alternating every cycle for 10 cycles → 5 `press` and 5 `release` pulses, never both in the same cycle.

Source files
------------

// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
//   Definitions shared by the button_event block and its timer.
//   - btn_state_t          : hold-tracking FSM state (IDLE, SHORT, LONG)
//   - BTN_CNT_BITS_DEFAULT : default hold/repeat counter width
// ----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // button released
        SHORT = 2'd1,   // held, long-press threshold not yet reached
        LONG  = 2'd2    // held, long-press already issued
    } btn_state_t;

    // Wide enough for the default 50M-cycle long-press threshold.
    localparam int BTN_CNT_BITS_DEFAULT = 26;

endpackage : button_pkg

// File: rtl/button_event_if.sv
// ----------------------------------------------------------------------------
// button_event_if
//   Groups the debounced button level and the event outputs of button_event.
//   `release` and `repeat` are SystemVerilog keywords, so those two events
//   travel as release_evt and repeat_evt.
//
//   Signals:
//     clean       debounced button level, 1 = pressed (synchronous to clk)
//     press       one-cycle pulse on the rising edge of clean
//     release_evt one-cycle pulse on the falling edge of clean
//     long_press  one-cycle pulse after LONG_CYCLES of continuous hold
//     repeat_evt  one-cycle pulse every REPEAT_CYCLES while in long-hold
//     held        level, high from the press cycle to the cycle before release
//
//   Modports:
//     master : source of the level / consumer of the events
//     slave  : the button_event block itself
// ----------------------------------------------------------------------------
interface button_event_if;

    logic clean;
    logic press;
    logic release_evt;
    logic long_press;
    logic repeat_evt;
    logic held;

    modport master (
        output clean,
        input  press, release_evt, long_press, repeat_evt, held
    );

    modport slave (
        input  clean,
        output press, release_evt, long_press, repeat_evt, held
    );

endinterface : button_event_if

// File: rtl/button_event_timer.sv
// ----------------------------------------------------------------------------
// event_timer
//   Up-counter with synchronous clear, count enable and a terminal-count
//   compare against a run-time `limit`. One instance serves both the
//   long-press and the repeat thresholds; the owner switches `limit` and
//   pulses `clr` whenever a new interval starts.
//
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     clr        : force the count to 0 (priority over en)
//     en         : advance the count this cycle
//     limit      : terminal count (interval length - 1)
//     expired    : en is high and the count has reached limit
// ----------------------------------------------------------------------------
module event_timer #(
    parameter int CNT_BITS = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [CNT_BITS-1:0] limit,
    output logic                expired
);

    logic [CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // The owner clears on expiry, so the count never runs past limit and
    // never wraps through the top of CNT_BITS.
    assign expired = en && (count_q == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : event_timer

// File: rtl/button_event.sv
// ----------------------------------------------------------------------------
// button_event
//   Turns the debounced button level into single-cycle events: press,
//   release, long-press and (optionally) auto-repeat, plus a `held` level.
//   The input must already be synchronous to clk; there is no synchronizer.
//
//   Parameters:
//     LONG_CYCLES   cycles from press to long_press (>= 2)
//     REPEAT_CYCLES repeat period while in long-hold (>= 2)
//     CNT_BITS      timer width, must hold max(LONG,REPEAT) - 1
//
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-high reset
//     bus   : button_event_if.slave (clean in; press, release_evt,
//             long_press, repeat_evt, held out)
//
//   Build option:
//     BUTTON_AUTOREPEAT_EN - when defined, repeat_evt pulses every
//     REPEAT_CYCLES in LONG. When undefined, repeat_evt is constant 0 and
//     the timer holds at 0 in LONG.
//
//   All outputs are registered: an event appears in the cycle after the
//   clock edge that sampled the causing input.
// ----------------------------------------------------------------------------
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_BITS      = BTN_CNT_BITS_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    button_event_if.slave bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (LONG_CYCLES < 2) begin : g_chk_long
        $error("button_event: LONG_CYCLES must be >= 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_chk_repeat
        $error("button_event: REPEAT_CYCLES must be >= 2");
    end
    if ((longint'(LONG_CYCLES) - 1) >= (longint'(1) << CNT_BITS) ||
        (longint'(REPEAT_CYCLES) - 1) >= (longint'(1) << CNT_BITS)) begin : g_chk_bits
        $error("button_event: CNT_BITS too narrow for the thresholds");
    end

    localparam logic [CNT_BITS-1:0] LONG_LIMIT = CNT_BITS'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_BITS-1:0] REP_LIMIT  = CNT_BITS'(REPEAT_CYCLES - 1);
`endif

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    btn_state_t state_q, state_d;
    logic       clean_q, clean_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       long_q, long_d;
    logic       repeat_q, repeat_d;
    logic       held_q, held_d;

    logic                rise, fall;
    logic                tmr_clr, tmr_en, tmr_expired;
    logic [CNT_BITS-1:0] tmr_limit;

    // clean_q always mirrors the previous sample, so edges are simply
    // disagreements between the live level and that copy.
    assign rise = bus.clean & ~clean_q;
    assign fall = ~bus.clean & clean_q;

    // ------------------------------------------------------------------
    // Next-state / event logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clean_d   = bus.clean;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = LONG_LIMIT;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SHORT;
                    press_d = 1'b1;
                    tmr_clr = 1'b1;
                end
            end

            SHORT: begin
                // A falling edge is checked first so that release wins
                // over a coincident long-press expiry.
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                end else begin
                    tmr_en    = 1'b1;
                    tmr_limit = LONG_LIMIT;
                    if (tmr_expired) begin
                        state_d = LONG;
                        long_d  = 1'b1;
                        tmr_clr = 1'b1;
                    end
                end
            end

            LONG: begin
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    tmr_clr   = 1'b1;
                end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                    tmr_en    = 1'b1;
                    tmr_limit = REP_LIMIT;
                    if (tmr_expired) begin
                        repeat_d = 1'b1;
                        tmr_clr  = 1'b1;
                    end
`else
                    // Timer was cleared on entry and stays parked at 0.
                    tmr_en = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                tmr_clr = 1'b1;
            end
        endcase

        // held tracks the registered state, so it rises with press and
        // falls with release.
        held_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // Shared interval timer
    // ------------------------------------------------------------------
    event_timer #(
        .CNT_BITS (CNT_BITS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clean_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign bus.press       = press_q;
    assign bus.release_evt = release_q;
    assign bus.long_press  = long_q;
    assign bus.repeat_evt  = repeat_q;
    assign bus.held        = held_q;

endmodule : button_event
